// File: rtl/add_frame_head_if.sv
// Stream bundle between pam_map, the frame-head inserter and the DAC path.
// The master modport is the framer side; the slave modport is its environment.
interface add_frame_head_if #(
    parameter int unsigned AD_CVER_WIDTH = 12
);
    localparam int unsigned BEAT_W = 2 * AD_CVER_WIDTH;

    logic              PamMap2AddHead_valid;
    logic [BEAT_W-1:0] PamMap2AddHead_data;
    logic              PamMap2AddHead_ready;
    logic              AddHead2Dac_valid;
    logic [BEAT_W-1:0] AddHead2Dac_data;
    logic              AddHead2Dac_last;
    logic              AddHead2Dac_ready;

    modport master (
        input  PamMap2AddHead_valid,
        input  PamMap2AddHead_data,
        output PamMap2AddHead_ready,
        output AddHead2Dac_valid,
        output AddHead2Dac_data,
        output AddHead2Dac_last,
        input  AddHead2Dac_ready
    );

    modport slave (
        output PamMap2AddHead_valid,
        output PamMap2AddHead_data,
        input  PamMap2AddHead_ready,
        input  AddHead2Dac_valid,
        input  AddHead2Dac_data,
        input  AddHead2Dac_last,
        output AddHead2Dac_ready
    );
endinterface

// File: rtl/add_frame_head.sv
// Framer: pilot header, PAM payload and zero guard beats into one-beat output register.
// Optional FRAME_CNT_EN inserts a 16-bit frame-count beat after the last pilot.
module add_frame_head #(
    parameter int unsigned AD_CVER_WIDTH = 12,
    parameter int unsigned HEAD_LEN      = 16,
    parameter int unsigned PAYLOAD_LEN   = 256,
    parameter int unsigned GUARD_LEN     = 4,
    parameter int unsigned CNT_WIDTH     = 9
) (
    input  logic             clk,
    input  logic             arst_n,
    add_frame_head_if.master bus,
    output logic             frame_busy
);
    localparam int unsigned BEAT_W = 2 * AD_CVER_WIDTH;

    localparam logic [AD_CVER_WIDTH-1:0] POS = {1'b0, {(AD_CVER_WIDTH-1){1'b1}}};
    localparam logic [AD_CVER_WIDTH-1:0] NEG = {1'b1, {(AD_CVER_WIDTH-2){1'b0}}, 1'b1};
    localparam logic [BEAT_W-1:0] PILOT_EVEN = {NEG, POS};
    localparam logic [BEAT_W-1:0] PILOT_ODD  = {POS, NEG};

    localparam logic [CNT_WIDTH-1:0] HEAD_LAST  = CNT_WIDTH'(HEAD_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] PAY_LAST   = CNT_WIDTH'(PAYLOAD_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
`ifdef FRAME_CNT_EN
        ST_CNT,
`endif
        ST_PAY,
        ST_GUARD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [BEAT_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                up_ready_c;
    logic                xfer_c;
    logic                load_ok_c;

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Frame counter advances when the closing beat of a frame leaves the block.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            frame_cnt_q <= '0;
        end else if (xfer_c && out_last_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next state and output-register load; the register empties when its beat transfers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        xfer_c      = out_valid_q & bus.AddHead2Dac_ready;
        load_ok_c   = ~out_valid_q | bus.AddHead2Dac_ready;
        out_valid_d = out_valid_q & ~bus.AddHead2Dac_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        up_ready_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Wait for the previous frame's last beat to drain: this is the inter-frame bubble.
                if (bus.PamMap2AddHead_valid && !out_valid_q) begin
                    state_d     = ST_HEAD;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = PILOT_EVEN;
                    out_last_d  = 1'b0;
                end
            end
            ST_HEAD: begin
                if (xfer_c) begin
                    if (cnt_q == HEAD_LAST) begin
                        cnt_d = '0;
`ifdef FRAME_CNT_EN
                        state_d     = ST_CNT;
                        out_valid_d = 1'b1;
                        out_data_d  = BEAT_W'(frame_cnt_q);
                        out_last_d  = 1'b0;
`else
                        state_d = ST_PAY;
`endif
                    end else begin
                        cnt_d       = cnt_q + CNT_ONE;
                        out_valid_d = 1'b1;
                        out_data_d  = cnt_q[0] ? PILOT_EVEN : PILOT_ODD;
                        out_last_d  = 1'b0;
                    end
                end
            end
`ifdef FRAME_CNT_EN
            ST_CNT: begin
                if (xfer_c) begin
                    state_d = ST_PAY;
                end
            end
`endif
            ST_PAY: begin
                up_ready_c = load_ok_c;
                if (bus.PamMap2AddHead_valid && load_ok_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.PamMap2AddHead_data;
                    out_last_d  = 1'b0;
                    if (cnt_q == PAY_LAST) begin
                        cnt_d = '0;
                        if (GUARD_LEN == 0) begin
                            out_last_d = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            state_d = ST_GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_GUARD: begin
                if (load_ok_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_last_d  = (cnt_q == GUARD_LAST);
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.PamMap2AddHead_ready = up_ready_c;
    assign bus.AddHead2Dac_valid    = out_valid_q;
    assign bus.AddHead2Dac_data     = out_data_q;
    assign bus.AddHead2Dac_last     = out_last_q;
    assign frame_busy               = (state_q != ST_IDLE);
endmodule

// File: tb/tb_add_frame_head.sv
// Directed bench for add_frame_head: default framer plus a short GUARD_LEN=0 instance.
module tb_add_frame_head;
    localparam int unsigned W  = 12;
    localparam int unsigned BW = 2 * W;
    localparam int unsigned HL = 16;
    localparam int unsigned PL = 256;
    localparam int unsigned GL = 4;
`ifdef FRAME_CNT_EN
    localparam int unsigned CB = 1;
    localparam int N0 = 9;
    localparam bit          E0_V [N0] = '{1, 1, 1, 0, 1, 1, 1, 0, 1};
    localparam logic [23:0] E0_D [N0] = '{24'h801_7FF, 24'h7FF_801, 24'h000000, 24'h0,
                                          24'hABC000, 24'hABC001, 24'hABC002, 24'h0, 24'h801_7FF};
    localparam bit          E0_L [N0] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    localparam bit          E0_B [N0] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};
`else
    localparam int unsigned CB = 0;
    localparam int N0 = 9;
    localparam bit          E0_V [N0] = '{1, 1, 0, 1, 1, 1, 0, 1, 1};
    localparam logic [23:0] E0_D [N0] = '{24'h801_7FF, 24'h7FF_801, 24'h0, 24'hABC000,
                                          24'hABC001, 24'hABC002, 24'h0, 24'h801_7FF, 24'h7FF_801};
    localparam bit          E0_L [N0] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
    localparam bit          E0_B [N0] = '{1, 1, 1, 1, 1, 0, 0, 1, 1};
`endif
    localparam int unsigned FL = HL + CB + PL + GL;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, busy0;
    always #5 clk = ~clk;

    add_frame_head_if #(.AD_CVER_WIDTH(W)) bus ();
    add_frame_head_if #(.AD_CVER_WIDTH(W)) bus0 ();

    add_frame_head #(.AD_CVER_WIDTH(W), .HEAD_LEN(HL), .PAYLOAD_LEN(PL), .GUARD_LEN(GL), .CNT_WIDTH(9))
        u_dut (.clk(clk), .arst_n(rst_n), .bus(bus), .frame_busy(busy));

    add_frame_head #(.AD_CVER_WIDTH(W), .HEAD_LEN(2), .PAYLOAD_LEN(3), .GUARD_LEN(0), .CNT_WIDTH(2))
        u_dut0 (.clk(clk), .arst_n(rst_n), .bus(bus0), .frame_busy(busy0));

    int n_tests = 0;
    int n_fail  = 0;
    int beat = 0;
    int frame_no = 0;
    int in_idx = 0;
    bit hold_pend = 0;
    logic [BW-1:0] held_data;
    logic held_last;
    logic [BW-1:0] pay_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pilot(input int k);
        return (k % 2 == 0) ? 24'h801_7FF : 24'h7FF_801;
    endfunction

    // Hold reset, check the reset state, clear the reference model, release at posedge+1.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.PamMap2AddHead_valid  = 1'b0;
        bus.PamMap2AddHead_data   = '0;
        bus.AddHead2Dac_ready     = 1'b0;
        bus0.PamMap2AddHead_valid = 1'b0;
        bus0.PamMap2AddHead_data  = '0;
        bus0.AddHead2Dac_ready    = 1'b0;
        hold_pend = 0;
        beat = 0;
        frame_no = 0;
        pay_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(bus.AddHead2Dac_valid), 0);
        check("rst_data", 32'(bus.AddHead2Dac_data), 0);
        check("rst_last", 32'(bus.AddHead2Dac_last), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_upready", 32'(bus.PamMap2AddHead_ready), 0);
        rst_n = 1'b1;
    endtask

    // One cycle on the main DUT; called at posedge+1, returns at the next posedge+1.
    task automatic step(input bit rdy, input bit vld);
        logic [BW-1:0] exp_d;
        bit exp_l;
        bus.AddHead2Dac_ready    = rdy;
        bus.PamMap2AddHead_valid = vld;
        bus.PamMap2AddHead_data  = 24'h345600 + BW'(in_idx);
        #1;
        if (hold_pend) begin
            check("hold_valid", 32'(bus.AddHead2Dac_valid), 1);
            check("hold_data", 32'(bus.AddHead2Dac_data), 32'(held_data));
            check("hold_last", 32'(bus.AddHead2Dac_last), 32'(held_last));
        end
        if (bus.AddHead2Dac_valid && rdy) begin
            if (beat < int'(HL)) exp_d = pilot(beat);
            else if (CB == 1 && beat == int'(HL)) exp_d = BW'(frame_no[15:0]);
            else if (beat < int'(HL + CB + PL)) exp_d = (pay_q.size() > 0) ? pay_q.pop_front() : 'x;
            else exp_d = '0;
            exp_l = (beat == int'(FL) - 1);
            check($sformatf("beat_data f%0d b%0d", frame_no, beat), 32'(bus.AddHead2Dac_data), 32'(exp_d));
            check($sformatf("beat_last f%0d b%0d", frame_no, beat), 32'(bus.AddHead2Dac_last), 32'(exp_l));
            if (exp_l) begin
                check("pay_left", 32'(pay_q.size()), 0);
                frame_no++;
                beat = 0;
            end else begin
                beat++;
            end
        end
        if (vld && bus.PamMap2AddHead_ready) begin
            pay_q.push_back(bus.PamMap2AddHead_data);
            in_idx++;
        end
        hold_pend = bus.AddHead2Dac_valid & ~rdy;
        held_data = bus.AddHead2Dac_data;
        held_last = bus.AddHead2Dac_last;
        @(posedge clk);
        #1;
    endtask

    // Modes: 0 continuous, 1 out ready 4-on/4-off, 2 input valid gaps, 3 random both.
    task automatic run_frames(input int nf, input int mode, input int budget);
        int target;
        int i;
        target = frame_no + nf;
        i = 0;
        while (frame_no < target && i < budget) begin
            case (mode)
                0:       step(1'b1, 1'b1);
                1:       step(i[2], 1'b1);
                2:       step(1'b1, i[2]);
                default: step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
            i++;
        end
        check($sformatf("frames_done mode%0d", mode), 32'(frame_no), 32'(target));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        bit acc_pend;
        int i;

        // GUARD_LEN=0 instance: last on final payload, IDLE bubble, then a new frame.
        do_reset();
        bus0.PamMap2AddHead_valid = 1'b1;
        bus0.AddHead2Dac_ready    = 1'b1;
        bus0.PamMap2AddHead_data  = 24'hABC000;
        acc0 = 0;
        acc_pend = 0;
        for (int k = 0; k < N0; k++) begin
            @(posedge clk);
            #1;
            if (acc_pend) begin
                acc0++;
                bus0.PamMap2AddHead_data = 24'hABC000 + BW'(acc0);
            end
            check($sformatf("g0_valid k%0d", k), 32'(bus0.AddHead2Dac_valid), 32'(E0_V[k]));
            check($sformatf("g0_busy k%0d", k), 32'(busy0), 32'(E0_B[k]));
            if (E0_V[k]) begin
                check($sformatf("g0_data k%0d", k), 32'(bus0.AddHead2Dac_data), 32'(E0_D[k]));
                check($sformatf("g0_last k%0d", k), 32'(bus0.AddHead2Dac_last), 32'(E0_L[k]));
            end
            acc_pend = bus0.PamMap2AddHead_valid & bus0.PamMap2AddHead_ready;
        end
        bus0.PamMap2AddHead_valid = 1'b0;

        // Main framer: first pilot latency, then continuous frames.
        do_reset();
        bus.AddHead2Dac_ready    = 1'b1;
        bus.PamMap2AddHead_valid = 1'b1;
        #1;
        check("idle_valid", 32'(bus.AddHead2Dac_valid), 0);
        check("idle_upready", 32'(bus.PamMap2AddHead_ready), 0);
        check("idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        check("first_valid", 32'(bus.AddHead2Dac_valid), 1);
        check("first_data", 32'(bus.AddHead2Dac_data), 32'h801_7FF);
        check("first_busy", 32'(busy), 1);
        run_frames(3, 0, 4000);
        run_frames(2, 1, 4000);
        run_frames(2, 2, 4000);
        run_frames(1, 3, 6000);

        // Reset at payload beat 100 abandons the frame; a fresh frame follows.
        i = 0;
        while (beat != int'(HL + CB + 100) && i < 1000) begin
            step(1'b1, 1'b1);
            i++;
        end
        check("reach_pay100", 32'(beat), 32'(HL + CB + 100));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(bus.AddHead2Dac_valid), 0);
        check("arst_data", 32'(bus.AddHead2Dac_data), 0);
        check("arst_last", 32'(bus.AddHead2Dac_last), 0);
        check("arst_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        do_reset();
        run_frames(2, 0, 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
